// File: rtl/fb_pkg.sv
// Shared framebuffer definitions: screen geometry, address width and the
// state encodings used by the plotter and the clear engine.
package fb_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int CENTER_Y      = SCREEN_HEIGHT / 2;
  localparam int ADDR_WIDTH    = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT);

  // Oscilloscope trace plotter states.
  typedef enum logic [2:0] {
    PLOT_WAIT_CLEAR,
    PLOT_ARMED,
    PLOT_COMPUTE,
    PLOT_DRAW,
    PLOT_FULL
  } plot_state_e;

  // Framebuffer clear engine states.
  typedef enum logic [1:0] {
    CLR_IDLE,
    CLR_RUN,
    CLR_DONE
  } clear_state_e;

endpackage

// File: rtl/sample_to_row.sv
// Combinational mapping of a signed audio sample to a screen row:
// arithmetic scale-down, flip around the centre line, clamp to the screen.
module sample_to_row
  import fb_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int COORD_WIDTH  = 16,
  parameter int SCALE_SHIFT  = 15
) (
  input  logic signed [SAMPLE_WIDTH-1:0] sample_i,
  output logic        [COORD_WIDTH-1:0]  row_o
);

  // Wide enough for both the sample and a coordinate plus a sign bit, so the
  // offset subtraction can never wrap before the clamp sees it.
  localparam int CW = ((SAMPLE_WIDTH > COORD_WIDTH) ? SAMPLE_WIDTH : COORD_WIDTH) + 1;

  localparam logic signed [CW-1:0]          CENTER_C = CW'(CENTER_Y);
  localparam logic signed [CW-1:0]          MAX_C    = CW'(SCREEN_HEIGHT - 1);
  localparam logic        [COORD_WIDTH-1:0] MAX_ROW  = COORD_WIDTH'(SCREEN_HEIGHT - 1);

  logic signed [CW-1:0] sample_ext;
  logic signed [CW-1:0] shifted;
  logic signed [CW-1:0] y_raw;

  assign sample_ext = {{(CW - SAMPLE_WIDTH){sample_i[SAMPLE_WIDTH-1]}}, sample_i};
  assign shifted    = sample_ext >>> SCALE_SHIFT;
  // Positive samples plot upward, so the scaled value is subtracted.
  assign y_raw      = CENTER_C - shifted;

  // Clamp the signed row into [0, SCREEN_HEIGHT-1].
  always_comb begin
    if (y_raw[CW-1]) begin
      row_o = '0;
    end else if (y_raw > MAX_C) begin
      row_o = MAX_ROW;
    end else begin
      row_o = y_raw[COORD_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/waveform_plotter.sv
// Oscilloscope trace plotter: decimates the audio stream and draws one
// vertically connected column per kept sample into the back framebuffer,
// only in the window between the end of a clear and the end of the frame.
module waveform_plotter
  import fb_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int COORD_WIDTH  = 16,
  parameter int SCALE_SHIFT  = 15,
  parameter int DECIMATE     = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                    sample_valid,
  output logic                    sample_ready,
  input  logic                    clearing_framebuffer,
  output logic [ADDR_WIDTH-1:0]   pixel_addr,
  output logic                    pixel_data,
  output logic                    pixel_wr_en,
  output logic                    frame_full
);

  localparam int DCW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

  localparam logic [DCW-1:0]         DECIM_LAST = DCW'(DECIMATE - 1);
  localparam logic [COORD_WIDTH-1:0] X_LAST     = COORD_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] CENTER_ROW = COORD_WIDTH'(CENTER_Y);
  localparam logic [ADDR_WIDTH-1:0]  ROW_PITCH  = ADDR_WIDTH'(SCREEN_WIDTH);

  // Linear framebuffer index; the multiplier is a constant, so this reduces
  // to shifts and adds ahead of the address register.
  function automatic logic [ADDR_WIDTH-1:0] pixel_index(
    input logic [COORD_WIDTH-1:0] y,
    input logic [COORD_WIDTH-1:0] x
  );
    return ADDR_WIDTH'(y) * ROW_PITCH + ADDR_WIDTH'(x);
  endfunction

  plot_state_e              state_q, state_d;
  logic [COORD_WIDTH-1:0]   x_q, x_d;
  logic [DCW-1:0]           decim_q, decim_d;
  logic [COORD_WIDTH-1:0]   prev_y_q, prev_y_d;
  logic [COORD_WIDTH-1:0]   y_cur_q, y_cur_d;
  logic [COORD_WIDTH-1:0]   y_end_q, y_end_d;
  logic                     first_col_q, first_col_d;
  logic [SAMPLE_WIDTH-1:0]  sample_q, sample_d;
  logic                     clr_q;
  logic                     sample_ready_q, sample_ready_d;
  logic [ADDR_WIDTH-1:0]    pixel_addr_q, pixel_addr_d;
  logic                     pixel_data_q, pixel_data_d;
  logic                     pixel_wr_en_q, pixel_wr_en_d;
  logic                     frame_full_q, frame_full_d;

  logic                     clear_done;
  logic                     handshake;
  logic [COORD_WIDTH-1:0]   row_new;
  logic [COORD_WIDTH-1:0]   y_start;

  assign clear_done = clr_q & ~clearing_framebuffer;
  assign handshake  = sample_valid & sample_ready_q;

  sample_to_row #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .COORD_WIDTH  (COORD_WIDTH),
    .SCALE_SHIFT  (SCALE_SHIFT)
  ) u_sample_to_row (
    .sample_i (sample_q),
    .row_o    (row_new)
  );

  // Next-state and registered-output logic for the plotter FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    x_d           = x_q;
    decim_d       = decim_q;
    prev_y_d      = prev_y_q;
    y_cur_d       = y_cur_q;
    y_end_d       = y_end_q;
    first_col_d   = first_col_q;
    sample_d      = sample_q;
    pixel_addr_d  = pixel_addr_q;
    pixel_wr_en_d = 1'b0;
    frame_full_d  = frame_full_q;
    y_start       = prev_y_q;

    unique case (state_q)
      PLOT_WAIT_CLEAR: begin
        if (clear_done) begin
          state_d      = PLOT_ARMED;
          x_d          = '0;
          decim_d      = '0;
          first_col_d  = 1'b1;
          frame_full_d = 1'b0;
        end
      end

      PLOT_ARMED: begin
        if (handshake) begin
          if (decim_q == DECIM_LAST) begin
            sample_d = sample_data;
            decim_d  = '0;
            state_d  = PLOT_COMPUTE;
          end else begin
            decim_d = decim_q + 1'b1;
          end
        end
      end

      PLOT_COMPUTE: begin
        // The first column of a frame has no predecessor to connect to.
        y_start       = first_col_q ? row_new : prev_y_q;
        y_cur_d       = y_start;
        y_end_d       = row_new;
        pixel_wr_en_d = 1'b1;
        pixel_addr_d  = pixel_index(y_start, x_q);
        state_d       = PLOT_DRAW;
      end

      PLOT_DRAW: begin
        // The registered write of y_cur_q is on the port this cycle.
        if (y_cur_q == y_end_q) begin
          prev_y_d    = y_end_q;
          first_col_d = 1'b0;
          if (x_q == X_LAST) begin
            frame_full_d = 1'b1;
            state_d      = PLOT_FULL;
          end else begin
            x_d     = x_q + 1'b1;
            state_d = PLOT_ARMED;
          end
        end else begin
          y_cur_d       = (y_cur_q < y_end_q) ? y_cur_q + 1'b1 : y_cur_q - 1'b1;
          pixel_wr_en_d = 1'b1;
          pixel_addr_d  = pixel_index(y_cur_d, x_q);
        end
      end

      PLOT_FULL: begin
        // Samples are acknowledged and dropped until the next clear.
      end

      default: state_d = PLOT_WAIT_CLEAR;
    endcase

    // A clear in progress owns the framebuffer and aborts any drawing.
    if (clearing_framebuffer) begin
      state_d       = PLOT_WAIT_CLEAR;
      pixel_wr_en_d = 1'b0;
      frame_full_d  = 1'b0;
    end

    sample_ready_d = (state_d == PLOT_WAIT_CLEAR) ||
                     (state_d == PLOT_ARMED)      ||
                     (state_d == PLOT_FULL);
    pixel_data_d   = pixel_wr_en_d;
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset along with the control state so
    // a reset mid-frame can never leave a stale coordinate behind.
    if (reset) begin
      state_q        <= PLOT_WAIT_CLEAR;
      x_q            <= '0;
      decim_q        <= '0;
      prev_y_q       <= CENTER_ROW;
      y_cur_q        <= '0;
      y_end_q        <= '0;
      first_col_q    <= 1'b1;
      sample_q       <= '0;
      clr_q          <= 1'b0;
      sample_ready_q <= 1'b0;
      pixel_addr_q   <= '0;
      pixel_data_q   <= 1'b0;
      pixel_wr_en_q  <= 1'b0;
      frame_full_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, independent of statement order.
      state_q        <= state_d;
      x_q            <= x_d;
      decim_q        <= decim_d;
      prev_y_q       <= prev_y_d;
      y_cur_q        <= y_cur_d;
      y_end_q        <= y_end_d;
      first_col_q    <= first_col_d;
      sample_q       <= sample_d;
      clr_q          <= clearing_framebuffer;
      sample_ready_q <= sample_ready_d;
      pixel_addr_q   <= pixel_addr_d;
      pixel_data_q   <= pixel_data_d;
      pixel_wr_en_q  <= pixel_wr_en_d;
      frame_full_q   <= frame_full_d;
    end
  end

  assign sample_ready = sample_ready_q;
  assign pixel_addr   = pixel_addr_q;
  assign pixel_data   = pixel_data_q;
  assign pixel_wr_en  = pixel_wr_en_q;
  assign frame_full   = frame_full_q;

endmodule

// File: tb/tb_waveform_plotter.sv
// Directed bench for waveform_plotter: one instance with DECIMATE=1 for the
// drawing behaviour and one with DECIMATE=4 for sample decimation.
module tb_waveform_plotter;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clr = 1'b0;

  logic [23:0] s1_data = '0;
  logic        s1_valid = 1'b0;
  logic        r1, data1, we1, full1;
  logic [ADDR_WIDTH-1:0] addr1;

  logic [23:0] s4_data = '0;
  logic        s4_valid = 1'b0;
  logic        r4, data4, we4, full4;
  logic [ADDR_WIDTH-1:0] addr4;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  waveform_plotter #(.DECIMATE(1)) u_dut1 (
    .clk                  (clk),
    .reset                (reset),
    .sample_data          (s1_data),
    .sample_valid         (s1_valid),
    .sample_ready         (r1),
    .clearing_framebuffer (clr),
    .pixel_addr           (addr1),
    .pixel_data           (data1),
    .pixel_wr_en          (we1),
    .frame_full           (full1)
  );

  waveform_plotter #(.DECIMATE(4)) u_dut4 (
    .clk                  (clk),
    .reset                (reset),
    .sample_data          (s4_data),
    .sample_valid         (s4_valid),
    .sample_ready         (r4),
    .clearing_framebuffer (clr),
    .pixel_addr           (addr4),
    .pixel_data           (data4),
    .pixel_wr_en          (we4),
    .frame_full           (full4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plot one column on the DECIMATE=1 instance and check every write.
  task automatic plot1(input logic [23:0] smp, input int x, input int y_from, input int y_to);
    int y;
    int n;
    check($sformatf("ready_armed x%0d", x), 32'(r1), 32'd1);
    s1_data  = smp;
    s1_valid = 1'b1;
    tick();
    s1_valid = 1'b0;
    check($sformatf("ready_compute x%0d", x), 32'(r1), 32'd0);
    n = ((y_to > y_from) ? (y_to - y_from) : (y_from - y_to)) + 1;
    y = y_from;
    for (int k = 0; k < n; k++) begin
      tick();
      check($sformatf("we x%0d y%0d", x, y), 32'(we1), 32'd1);
      check($sformatf("addr x%0d y%0d", x, y), 32'(addr1), 32'(y * SCREEN_WIDTH + x));
      check($sformatf("data x%0d y%0d", x, y), 32'(data1), 32'd1);
      check($sformatf("addr_range x%0d y%0d", x, y), 32'(addr1 < 19'd307200), 32'd1);
      check($sformatf("ready_draw x%0d y%0d", x, y), 32'(r1), 32'd0);
      y += (y_to > y_from) ? 1 : -1;
    end
    tick();
    check($sformatf("we_end x%0d", x), 32'(we1), 32'd0);
    check($sformatf("ready_end x%0d", x), 32'(r1), 32'd1);
    check($sformatf("full_end x%0d", x), 32'(full1), 32'(x == SCREEN_WIDTH - 1));
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    check("rst_ready", 32'(r1), 32'd0);
    check("rst_addr", 32'(addr1), 32'd0);
    check("rst_data", 32'(data1), 32'd0);
    check("rst_we", 32'(we1), 32'd0);
    check("rst_full", 32'(full1), 32'd0);
    reset = 1'b0;
    tick();
    check("waitclear_ready", 32'(r1), 32'd1);

    // Samples before the first clear are discarded.
    s1_data  = 24'h000000;
    s1_valid = 1'b1;
    tick();
    s1_valid = 1'b0;
    check("waitclear_no_we0", 32'(we1), 32'd0);
    tick();
    check("waitclear_no_we1", 32'(we1), 32'd0);
    check("waitclear_ready1", 32'(r1), 32'd1);

    // One-cycle clear pulse arms both instances.
    clr = 1'b1;
    tick();
    check("clear_ready", 32'(r1), 32'd1);
    check("clear_we", 32'(we1), 32'd0);
    clr = 1'b0;
    tick();

    // Columns 0 and 1: centre line, then a connected run up to row 230.
    plot1(24'h000000, 0, 240, 240);
    plot1(24'h050000, 1, 240, 230);
    // prev_y is now 230, so an equal sample yields a single pixel.
    plot1(24'h050000, 2, 230, 230);
    // Clamped extremes: full-scale positive -> row 0, full-scale negative -> 479.
    plot1(24'h7FFFFF, 3, 230, 0);
    plot1(24'h800000, 4, 0, 479);

    // DECIMATE=4: only every fourth accepted sample produces a column.
    for (int i = 0; i < 3; i++) begin
      s4_data  = 24'h7FFFFF;
      s4_valid = 1'b1;
      tick();
      check($sformatf("d4_skip_a%0d_we", i), 32'(we4), 32'd0);
      check($sformatf("d4_skip_a%0d_ready", i), 32'(r4), 32'd1);
    end
    s4_data = 24'h000000;
    tick();
    s4_valid = 1'b0;
    check("d4_trig_a_ready", 32'(r4), 32'd0);
    tick();
    check("d4_col0_we", 32'(we4), 32'd1);
    check("d4_col0_addr", 32'(addr4), 32'd153600);
    tick();
    check("d4_col0_done", 32'(we4), 32'd0);
    for (int i = 0; i < 3; i++) begin
      s4_data  = 24'h800000;
      s4_valid = 1'b1;
      tick();
      check($sformatf("d4_skip_b%0d_we", i), 32'(we4), 32'd0);
    end
    s4_data = 24'h050000;
    tick();
    s4_valid = 1'b0;
    check("d4_trig_b_ready", 32'(r4), 32'd0);
    for (int k = 0; k < 11; k++) begin
      tick();
      check($sformatf("d4_col1_we%0d", k), 32'(we4), 32'd1);
      check($sformatf("d4_col1_addr%0d", k), 32'(addr4), 32'((240 - k) * SCREEN_WIDTH + 1));
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("d4_idle_we%0d", k), 32'(we4), 32'd0);
    end

    // Fill the remaining columns; the first returns from row 479.
    plot1(24'h000000, 5, 479, 240);
    for (int x = 6; x < SCREEN_WIDTH; x++) begin
      plot1(24'h000000, x, 240, 240);
    end

    // Full: samples accepted, nothing written.
    s1_data  = 24'h050000;
    s1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("full_we%0d", i), 32'(we1), 32'd0);
      check($sformatf("full_flag%0d", i), 32'(full1), 32'd1);
      check($sformatf("full_ready%0d", i), 32'(r1), 32'd1);
    end
    s1_valid = 1'b0;

    // A new clear drops frame_full and restarts at column 0.
    clr = 1'b1;
    tick();
    check("reclear_full", 32'(full1), 32'd0);
    check("reclear_we", 32'(we1), 32'd0);
    clr = 1'b0;
    tick();
    plot1(24'h000000, 0, 240, 240);

    // Clear arriving mid-column (240 down to 190) aborts the draw.
    s1_data  = 24'h190000;
    s1_valid = 1'b1;
    tick();
    s1_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("abort_addr%0d", k), 32'(addr1), 32'((240 - k) * SCREEN_WIDTH + 1));
    end
    clr = 1'b1;
    tick();
    check("abort_we", 32'(we1), 32'd0);
    check("abort_ready", 32'(r1), 32'd1);
    check("abort_full", 32'(full1), 32'd0);
    clr = 1'b0;
    tick();
    check("abort_we_after", 32'(we1), 32'd0);
    tick();
    check("abort_we_idle", 32'(we1), 32'd0);
    plot1(24'h000000, 0, 240, 240);

    // Reset arriving mid-column clears every output on the next edge.
    s1_data  = 24'h190000;
    s1_valid = 1'b1;
    tick();
    s1_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("prereset_addr%0d", k), 32'(addr1), 32'((240 - k) * SCREEN_WIDTH + 1));
    end
    reset = 1'b1;
    tick();
    check("midrst_ready", 32'(r1), 32'd0);
    check("midrst_addr", 32'(addr1), 32'd0);
    check("midrst_data", 32'(data1), 32'd0);
    check("midrst_we", 32'(we1), 32'd0);
    check("midrst_full", 32'(full1), 32'd0);
    reset = 1'b0;
    tick();
    check("postrst_we", 32'(we1), 32'd0);
    check("postrst_ready", 32'(r1), 32'd1);
    tick();
    check("postrst_we_idle", 32'(we1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
